// File: rtl/spi_slave_fifo_pkg.sv
// spi_pkg: shared SPI slave types, constants and edge-role helper
package spi_pkg;
  typedef enum logic {IDLE, ACTIVE} spi_state_t;
  localparam int SPI_MIN_CLK_RATIO = 8;
  typedef struct packed {
    logic sample_rise;
    logic shift_rise;
  } spi_edge_sel_t;
  function automatic spi_edge_sel_t edge_sel(input logic cpol, input logic cpha);
    spi_edge_sel_t s;
    s.sample_rise = ~(cpol ^ cpha);
    s.shift_rise = cpol ^ cpha;
    return s;
  endfunction
endpackage

// File: rtl/spi_slave_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy level; push while full only lands alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout = mem[rd_ptr];
  // storage array, written only when the push is accepted
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
  // pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end
endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave, any CPOL/CPHA, TX FIFO on MISO; SPI_LSB_FIRST_EN selects LSB-first shifting
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TX_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      cs_bar,
  input  logic                      sclk,
  input  logic                      mosi,
  output logic                      miso,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_push,
  output logic                      tx_full,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      tx_done,
  output logic                      underrun,
  input  logic                      underrun_clr
);
  localparam int CW = $clog2(DATA_W + 1);
  spi_state_t state, state_nxt;
  spi_edge_sel_t sel_q;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_fall, cs_rise;
  logic sample_ev, shift_ev, word_done, load;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_sh, rx_next, tx_sh, tx_shifted, fifo_dout;
  logic tx_bit, fifo_empty;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  assign sample_ev = (state == ACTIVE) & ~cs_rise & (sel_q.sample_rise ? rise : fall);
  assign shift_ev = (state == ACTIVE) & ~cs_rise & (sel_q.shift_rise ? rise : fall);
  assign word_done = sample_ev & (bit_cnt == CW'(DATA_W - 1));
`ifdef SPI_LSB_FIRST_EN
  assign rx_next = {mosi_s, rx_sh[DATA_W-1:1]};
  assign tx_shifted = {1'b0, tx_sh[DATA_W-1:1]};
  assign tx_bit = tx_sh[0];
`else
  assign rx_next = {rx_sh[DATA_W-2:0], mosi_s};
  assign tx_shifted = {tx_sh[DATA_W-2:0], 1'b0};
  assign tx_bit = tx_sh[DATA_W-1];
`endif
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_push),
    .din(tx_data),
    .pop(load),
    .dout(fifo_dout),
    .full(tx_full),
    .empty(fifo_empty),
    .level(tx_level)
  );
  // pin synchronisers plus one-cycle delayed copies for edge detection; cs idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync <= '1;
      mosi_sync <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      cs_d <= cs_s;
    end
  end
  // state register; clock mode is frozen at the moment of selection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cs_fall) sel_q <= edge_sel(cpol, cpha);
    end
  end
  // next state and load: load on selection and on every completed word
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    if (state == IDLE) begin
      state_nxt = cs_fall ? ACTIVE : IDLE;
      load = cs_fall;
    end else begin
      state_nxt = cs_rise ? IDLE : ACTIVE;
      load = word_done;
    end
  end
  // receive path: bit counter, rx shift register and word strobes; deselect drops a partial word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      rx_valid <= word_done;
      tx_done <= word_done;
      if (state == ACTIVE && cs_rise) bit_cnt <= '0;
      else if (sample_ev) begin
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        rx_sh <= rx_next;
        if (word_done) rx_data <= rx_next;
      end
    end
  end
  // transmit path: load from FIFO head (zeros on underrun), shift only once a bit has been sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh <= '0;
      miso <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (load) tx_sh <= fifo_empty ? '0 : fifo_dout;
      else if (shift_ev && bit_cnt != '0) tx_sh <= tx_shifted;
      miso <= (state == ACTIVE) ? tx_bit : 1'b0;
      underrun <= (load & fifo_empty) | (underrun & ~underrun_clr);
    end
  end
endmodule
